connect_router_buffered: RTL

Parametrised ring stop for the hierarchical ring (hring) connect level. It is the buffered successor of the bufferless connect router.
- Flits addressed to this node are ejected into a DEPTH-entry FIFO with a valid/ready drain handshake. When the FIFO is full, the flit is deflected onward instead of being dropped.
- Local injection uses valid/ready and is granted only into a free ring slot.
- Saturating deflection statistics and an injection-starvation flag are exported for the ring controller.

---
 rtl/connect_router_buffered_pkg.sv | 26 ++
 rtl/connect_router_buffered_if.sv | 40 ++++
 rtl/connect_router_buffered_ring_eject_fifo.sv | 61 ++++++
 rtl/connect_router_buffered.sv | 96 +++++++++
 4 files changed

// File: rtl/connect_router_buffered_pkg.sv
// Shared definitions for the buffered hring connect-level ring stop.
// Flit layout: bit 0 = valid, [ID_W:1] = destination ID,
// [2*ID_W:ID_W+1] = source ID, and the upper bits are payload.
// An empty slot is carried as an all-zero flit.
package connect_router_buffered_pkg;

  localparam int VALID_BIT = 0;

  // Field bounds are functions of ID_W so every user picks the same slices.
  function automatic int dest_lsb();
    return 1;
  endfunction

  function automatic int dest_msb(input int id_w);
    return id_w;
  endfunction

  function automatic int src_lsb(input int id_w);
    return id_w + 1;
  endfunction

  function automatic int src_msb(input int id_w);
    return 2 * id_w;
  endfunction

endpackage

// File: rtl/connect_router_buffered_if.sv
// Bundles the ring, injection and ejection signals of one ring stop.
// Handshakes: a transfer happens on a rising clk edge where valid && ready
// are both 1; valid never waits on ready. inj_ready is a combinational
// function of the ring slot only; eject_ready pops the FIFO head.
//   ring_in/ring_out  : upstream / registered downstream flit
//   inj_*             : local injection (data, valid, ready)
//   eject_*           : FIFO head, non-empty flag, pop, occupancy
//   deflect_cnt/starve: statistics exported to the ring controller
// modport master = environment side, modport slave = router side.
interface connect_router_buffered_if #(
  parameter int FLIT_W = 144,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = 16
);
  localparam int CW = $clog2(DEPTH + 1);

  logic [FLIT_W-1:0] ring_in;
  logic [FLIT_W-1:0] ring_out;
  logic [FLIT_W-1:0] inj_data;
  logic              inj_valid;
  logic              inj_ready;
  logic [FLIT_W-1:0] eject_data;
  logic              eject_valid;
  logic              eject_ready;
  logic [CW-1:0]     eject_count;
  logic [CNT_W-1:0]  deflect_cnt;
  logic              starve;

  modport master (
    output ring_in, inj_data, inj_valid, eject_ready,
    input  ring_out, inj_ready, eject_data, eject_valid, eject_count,
           deflect_cnt, starve
  );

  modport slave (
    input  ring_in, inj_data, inj_valid, eject_ready,
    output ring_out, inj_ready, eject_data, eject_valid, eject_count,
           deflect_cnt, starve
  );
endinterface

// File: rtl/connect_router_buffered_ring_eject_fifo.sv
// First-word-fall-through eject FIFO.
// Ports: clk, rst (async, active-high); i_push/i_data write side;
// i_pop pops the head when non-empty; o_data head (zero when empty),
// o_valid non-empty, o_count occupancy, o_full = (count == DEPTH).
// A push into a full FIFO is refused even if a pop happens the same cycle.
module ring_eject_fifo #(
  parameter int FLIT_W = 144,
  parameter int DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_push,
  input  logic [FLIT_W-1:0]          i_data,
  input  logic                       i_pop,
  output logic [FLIT_W-1:0]          o_data,
  output logic                       o_valid,
  output logic [$clog2(DEPTH+1)-1:0] o_count,
  output logic                       o_full
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [FLIT_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [CW-1:0]     r_count;
  logic              w_push;
  logic              w_pop;
  logic              w_empty;

  assign w_empty = (r_count == '0);
  assign o_full  = (r_count == CW'(DEPTH));
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !w_empty;

  // Storage is not reset; the head is masked to zero while empty.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_valid = !w_empty;
  assign o_data  = w_empty ? '0 : r_mem[r_rd_ptr];
  assign o_count = r_count;
endmodule

// File: rtl/connect_router_buffered.sv
// Buffered ring stop for the hring connect level.
// Ports: clk, rst (async, active-high) and bus (slave modport) carrying
// ring_in/ring_out, inj_data/inj_valid/inj_ready,
// eject_data/eject_valid/eject_ready/eject_count, deflect_cnt, starve.
// Local flits are ejected into a FIFO; when it is full they are deflected
// onward and counted. Injection takes any slot left free this cycle.
module connect_router_buffered
  import connect_router_buffered_pkg::*;
#(
  parameter int FLIT_W       = 144,
  parameter int ID_W         = 4,
  parameter int NODE_ID      = 0,
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 16,
  parameter int CNT_W        = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  connect_router_buffered_if.slave bus
);
  localparam int WW = $clog2(STARVE_LIMIT + 1);

  logic [FLIT_W-1:0] r_ring_out;
  logic [CNT_W-1:0]  r_deflect_cnt;
  logic [WW-1:0]     r_wait;
  logic              r_starve;

  logic [ID_W-1:0]   w_dest;
  logic              w_in_valid;
  logic              w_local;
  logic              w_full;
  logic              w_eject;
  logic              w_deflect;
  logic              w_slot_free;
  logic              w_accept;
  logic [FLIT_W-1:0] w_ring_nxt;
  logic [WW-1:0]     w_wait_nxt;

  assign w_in_valid  = bus.ring_in[VALID_BIT];
  assign w_dest      = bus.ring_in[dest_msb(ID_W):dest_lsb()];
  assign w_local     = w_in_valid && (w_dest == ID_W'(NODE_ID));
  assign w_eject     = w_local && !w_full;
  assign w_deflect   = w_local && w_full;
  assign w_slot_free = !w_in_valid || w_eject;
  assign w_accept    = bus.inj_valid && w_slot_free;
  assign bus.inj_ready = w_slot_free;

  ring_eject_fifo #(
    .FLIT_W(FLIT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .i_push (w_eject),
    .i_data (bus.ring_in),
    .i_pop  (bus.eject_ready),
    .o_data (bus.eject_data),
    .o_valid(bus.eject_valid),
    .o_count(bus.eject_count),
    .o_full (w_full)
  );

  // Transit traffic has priority; an ejected flit frees its slot.
  always_comb begin
    w_ring_nxt = '0;
    if (w_in_valid && !w_eject) w_ring_nxt = bus.ring_in;
    else if (bus.inj_valid)     w_ring_nxt = bus.inj_data;
  end

  // Wait counter: clears when idle or granted, else saturates at the limit.
  always_comb begin
    w_wait_nxt = r_wait;
    if (!bus.inj_valid || w_accept)   w_wait_nxt = '0;
    else if (r_wait != WW'(STARVE_LIMIT)) w_wait_nxt = r_wait + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ring_out    <= '0;
      r_deflect_cnt <= '0;
      r_wait        <= '0;
      r_starve      <= 1'b0;
    end else begin
      r_ring_out <= w_ring_nxt;
      if (w_deflect && (r_deflect_cnt != '1))
        r_deflect_cnt <= r_deflect_cnt + 1'b1;
      r_wait   <= w_wait_nxt;
      // starve follows the counter value being written this edge.
      r_starve <= (w_wait_nxt == WW'(STARVE_LIMIT));
    end
  end

  assign bus.ring_out    = r_ring_out;
  assign bus.deflect_cnt = r_deflect_cnt;
  assign bus.starve      = r_starve;
endmodule
